// File: rtl/code_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// the bubble encoding and the default halt sentinel.
package code_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        LOAD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/code_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the code memory port, steps the PC,
// handles stalls/redirects/halt, lets a program loader take the memory,
// and holds the IF/ID pipeline register.
module code_fetch_ctrl
    import code_fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       mem_addr_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              mem_we_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              load_req_i,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_wdata_i,
    output logic              load_gnt_o,
    output logic [31:0]       ifid_instr_o,
    output logic [31:0]       ifid_pc_o,
    output logic              ifid_valid_o,
    output logic              halted_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] redirect_target;
    logic [ADDR_W-1:0] fetch_addr;
    logic              unused_redirect_hi;

    // Redirect targets are word addresses truncated to the memory size.
    assign redirect_target    = redirect_pc_i[ADDR_W-1:0];
    assign unused_redirect_hi = ^redirect_pc_i[31:ADDR_W];

    // Grant and halt flags are pure decodes of the registered state, so they
    // change exactly one cycle after the transition is decided.
    assign load_gnt_o = (state_q == LOAD);
    assign halted_o   = (state_q == HALT);

    // The loader sees the memory directly while granted; the write strobe is
    // combinational so a write in a reset cycle still lands.
    assign fetch_addr  = load_gnt_o ? load_addr_i : pc_q;
    assign mem_addr_o  = {{(32-ADDR_W){1'b0}}, fetch_addr};
    assign mem_we_o    = load_gnt_o & load_we_i;
    assign mem_wdata_o = load_wdata_i;

    assign ifid_instr_o = instr_q;
    assign ifid_pc_o    = {{(32-ADDR_W){1'b0}}, ifid_pc_q};
    assign ifid_valid_o = valid_q;

    // Next-state, next-PC and next-IF/ID decision with the per-state priority
    // redirect > load entry > halt detect > stall > advance.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        ifid_pc_d = ifid_pc_q;
        valid_d   = valid_q;
        case (state_q)
            RUN: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else if (load_req_i) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = LOAD;
                end else if (!stall_i && mem_rdata_i == HALT_INSTR) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = HALT;
                end else if (!stall_i) begin
                    instr_d   = mem_rdata_i;
                    ifid_pc_d = pc_q;
                    valid_d   = 1'b1;
                    pc_d      = pc_q + 1'b1;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = RUN;
                end else if (load_req_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!load_req_i) begin
                    pc_d    = RESET_PC[ADDR_W-1:0];
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC[ADDR_W-1:0];
            instr_q   <= NOP_INSTR;
            ifid_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            ifid_pc_q <= ifid_pc_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_code_fetch_ctrl.sv
// Self-checking bench for code_fetch_ctrl: directed scenarios followed by
// randomized traffic, compared against a behavioural fetch model.
module tb_code_fetch_ctrl;
    import code_fetch_ctrl_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        load_req_i;
    logic        load_we_i;
    logic [7:0]  load_addr_i;
    logic [31:0] load_wdata_i;
    logic        load_gnt_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic        ifid_valid_o;
    logic        halted_o;

    logic [31:0] env_mem   [DEPTH];
    logic [31:0] model_mem [DEPTH];

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ifpc;
    logic        m_valid;
    logic        m_pc_known;

    int checks   = 0;
    int failures = 0;

    code_fetch_ctrl #(
        .ADDR_W    (8),
        .RESET_PC  (32'h0),
        .HALT_INSTR(32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .load_req_i   (load_req_i),
        .load_we_i    (load_we_i),
        .load_addr_i  (load_addr_i),
        .load_wdata_i (load_wdata_i),
        .load_gnt_o   (load_gnt_o),
        .ifid_instr_o (ifid_instr_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_valid_o (ifid_valid_o),
        .halted_o     (halted_o)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Code memory: combinational read, written on the clock edge.
    assign mem_rdata_i = env_mem[mem_addr_o[7:0]];

    // Memory write port driven by the design's write strobe.
    always @(posedge clk) begin
        if (mem_we_o === 1'b1) env_mem[mem_addr_o[7:0]] <= mem_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_pc       = 32'h0;
        m_instr    = 32'h0;
        m_ifpc     = 32'h0;
        m_valid    = 1'b0;
        m_pc_known = 1'b1;
    endtask

    task automatic check_regs();
        chk("ifid_instr", ifid_instr_o, m_instr);
        chk("ifid_valid", {31'h0, ifid_valid_o}, {31'h0, m_valid});
        chk("halted", {31'h0, halted_o}, {31'h0, m_mode == 1});
        chk("load_gnt", {31'h0, load_gnt_o}, {31'h0, m_mode == 2});
        if (m_pc_known) chk("ifid_pc", ifid_pc_o, m_ifpc);
    endtask

    // One clock of stimulus: drive at negedge, check the combinational memory
    // port, advance the model, then check the registered outputs after the edge.
    task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                        input logic lr, input logic lw, input logic [7:0] la, input logic [31:0] ld);
        logic [31:0] word;
        logic        gnt;
        @(negedge clk);
        rst           = r;
        stall_i       = s;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        load_req_i    = lr;
        load_we_i     = lw;
        load_addr_i   = la;
        load_wdata_i  = ld;
        #1;
        gnt = (m_mode == 2);
        chk("mem_addr", mem_addr_o, gnt ? {24'h0, la} : m_pc);
        chk("mem_we", {31'h0, mem_we_o}, {31'h0, gnt & lw});
        chk("mem_wdata", mem_wdata_o, ld);
        word = model_mem[m_pc[7:0]];
        if (gnt && lw) model_mem[la] = ld;
        if (r) begin
            model_reset();
        end else begin
            m_pc_known = 1'b0;
            if (m_mode == 0) begin
                if (rd) begin
                    m_pc    = rpc % 256;
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                end else if (lr) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                    m_mode  = 2;
                end else if (!s && word == 32'hFFFF_FFFF) begin
                    m_instr = 32'h0;
                    m_valid = 1'b0;
                    m_mode  = 1;
                end else if (s) begin
                    m_pc_known = m_valid;
                end else begin
                    m_instr    = word;
                    m_ifpc     = m_pc;
                    m_valid    = 1'b1;
                    m_pc       = (m_pc + 1) % 256;
                    m_pc_known = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (rd) begin
                    m_pc   = rpc % 256;
                    m_mode = 0;
                end else if (lr) begin
                    m_mode = 2;
                end
            end else begin
                if (!lr) begin
                    m_pc   = 32'h0;
                    m_mode = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 8'h0, 32'h0);
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        logic        lr_r;
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom & 32'h7FFF_FFFF;
            env_mem[i]   = w;
            model_mem[i] = w;
        end
        env_mem[0] = 32'hA000_000A; model_mem[0] = 32'hA000_000A;
        env_mem[1] = 32'h0B00_000B; model_mem[1] = 32'h0B00_000B;
        env_mem[2] = 32'h0C00_000C; model_mem[2] = 32'h0C00_000C;
        env_mem[3] = 32'h0D00_000D; model_mem[3] = 32'h0D00_000D;
        env_mem[6]   = 32'hFFFF_FFFF; model_mem[6]   = 32'hFFFF_FFFF;
        env_mem[40]  = 32'hFFFF_FFFF; model_mem[40]  = 32'hFFFF_FFFF;
        env_mem[200] = 32'hFFFF_FFFF; model_mem[200] = 32'hFFFF_FFFF;

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        load_req_i = 1'b0; load_we_i = 1'b0; load_addr_i = 8'h0; load_wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();

        adv(3);
        step(0, 1, 0, 32'h0, 0, 0, 8'h0, 32'h0);
        step(0, 1, 0, 32'h0, 0, 0, 8'h0, 32'h0);
        adv(3);

        step(0, 1, 1, 32'h10, 0, 0, 8'h0, 32'h0);
        adv(2);

        step(0, 0, 1, 32'h5, 0, 0, 8'h0, 32'h0);
        adv(2);
        step(0, 1, 0, 32'h0, 0, 0, 8'h0, 32'h0);
        adv(1);

        step(0, 0, 1, 32'hABCD_01FF, 0, 0, 8'h0, 32'h0);
        adv(2);

        step(0, 0, 0, 32'h0, 1, 1, 8'h00, 32'h1234_5678);
        step(0, 0, 0, 32'h0, 1, 1, 8'h00, 32'h1234_5678);
        step(0, 1, 1, 32'h33, 1, 0, 8'h07, 32'h0);
        step(0, 0, 0, 32'h0, 0, 0, 8'h00, 32'h0);
        adv(2);

        step(0, 0, 0, 32'h0, 1, 0, 8'h00, 32'h0);
        step(0, 0, 0, 32'h0, 1, 0, 8'h00, 32'h0);
        step(1, 0, 0, 32'h0, 1, 1, 8'h09, 32'h0909_0909);
        adv(2);
        step(0, 0, 1, 32'h9, 0, 0, 8'h00, 32'h0);
        adv(2);

        lr_r = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 14) == 0) lr_r = ~lr_r;
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom,
                 lr_r,
                 $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)),
                 $urandom & 32'h7FFF_FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_fetch_ctrl.md
Name: code_fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the word-addressed code memory (256 x 32, combinational read).
- Drives the fetch address, handles load-use stalls and EX-stage redirects, and produces the IF/ID pipeline register.
- Arbitrates the memory between the fetch path and a program-loader port; the loader has exclusive access while granted.
- Sits between the code memory, the hazard unit, EX branch resolution and the decode stage.

Parameters:
- ADDR_W, 8, word-address width of the code memory (2^ADDR_W words).
- RESET_PC, 0, fetch address after reset and after a load session.
- HALT_INSTR, 32'hFFFF_FFFF, sentinel encoding that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr_o  out  32  code-memory address; upper 32-ADDR_W bits are 0.
- mem_rdata_i  in  32  code-memory read data, same cycle as mem_addr_o.
- mem_we_o  out  1  code-memory write enable (loader only).
- mem_wdata_o  out  32  code-memory write data.
- stall_i  in  1  hazard-unit stall (load-use).
- redirect_i  in  1  taken branch/jump from EX.
- redirect_pc_i  in  32  redirect target word address; bits above ADDR_W ignored.
- load_req_i  in  1  loader requests the memory; held high for the whole session.
- load_we_i  in  1  loader write strobe.
- load_addr_i  in  ADDR_W  loader word address.
- load_wdata_i  in  32  loader write data.
- load_gnt_o  out  1  loader owns the memory.
- ifid_instr_o  out  32  IF/ID instruction (32'h0 = bubble).
- ifid_pc_o  out  32  IF/ID instruction address.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  fetch stopped on HALT_INSTR.

Behaviour:
- States: RUN, HALT, LOAD.
- Reset (rst sampled high at clk):
  - state=RUN, pc=RESET_PC.
  - ifid_instr_o=0, ifid_pc_o=0, ifid_valid_o=0.
  - halted_o=0, load_gnt_o=0.
- Address mux: mem_addr_o = load_gnt_o ? load_addr_i : pc, zero-extended.
- Write path: mem_we_o = load_gnt_o & load_we_i; mem_wdata_o = load_wdata_i.
- RUN, per-cycle priority: rst > redirect > load entry > halt detect > stall > advance.
  - redirect_i: pc<=redirect_pc_i[ADDR_W-1:0]; IF/ID <= bubble (instr 0, valid 0). Overrides stall_i.
  - load_req_i without redirect: IF/ID <= bubble, pc held, go to LOAD. load_gnt_o=1 from the next cycle.
  - mem_rdata_i==HALT_INSTR, no stall, no redirect: IF/ID <= bubble, pc held, go to HALT, halted_o=1 next cycle.
  - stall_i: pc and IF/ID hold their values (valid included).
  - Advance: IF/ID <= {mem_rdata_i, pc, valid=1}; pc <= pc+1, wrapping mod 2^ADDR_W (max address -> 0).
- HALT:
  - IF/ID holds the bubble; halted_o=1; stall_i is ignored.
  - redirect_i: pc<=target, halted_o<=0, go to RUN. This covers a halt fetched on a wrong path.
  - load_req_i without redirect: go to LOAD.
- LOAD:
  - load_gnt_o=1; IF/ID stays bubble; redirect_i and stall_i are ignored.
  - load_req_i low: load_gnt_o<=0, pc<=RESET_PC, halted_o<=0, go to RUN.
  - The first fetch from RESET_PC occurs in the cycle after exit.
- Fetch latency: instruction at pc appears on ifid_* one clock after pc is presented.
- Redirect penalty is 1 bubble plus whatever EX squashes.
- rst mid-LOAD or mid-HALT: immediate return to the reset values; an in-flight loader write in that cycle is still performed, because mem_we_o is combinational on the pre-reset grant.

Decomposition:
- Shared package/include holds the state encodings (RUN=2'd0, HALT=2'd1, LOAD=2'd2), the NOP/bubble constant 32'h0, and the HALT_INSTR default.
- No sub-module is needed.
- The address/write mux stays inline, together with the PC and IF/ID registers.

Test Plan:
- Straight-line fetch: memory words 0..3 = A,B,C,D, no stall -> ifid_pc_o 0,1,2,3 on cycles 1-4, ifid_instr_o A..D, valid=1.
- Stall: stall_i high for 2 cycles while ifid_pc_o=2 -> ifid_pc_o stays 2 and mem_addr_o stays 3; resumes with pc 3 afterwards.
- Redirect with stall: redirect_i=1, redirect_pc_i=32'h10, stall_i=1 at pc=5 -> next cycle valid=0, instr=0; then ifid_pc_o=16.
- Halt and wrap:
  - word 6 = 32'hFFFF_FFFF -> after ifid_pc_o=5, halted_o=1, valid=0, mem_addr_o frozen at 6.
  - With pc at 255 and advance -> next mem_addr_o = 0.
- Load session:
  - load_req_i during RUN, write 32'h1234_5678 to address 0x00 -> load_gnt_o=1 next cycle and mem_we_o pulses.
  - Drop load_req_i -> gnt=0; ifid_pc_o=0, instr=32'h1234_5678 two cycles later.
- Reset mid-LOAD: rst with load_gnt_o=1 -> next cycle load_gnt_o=0, state RUN, pc=0, valid=0, halted_o=0.
